// File: rtl/request_unit.sv
// ---------------------------------------------------------------------------
// request_unit
// Sequences instruction and data memory requests for a single-cycle RISC-V
// datapath. A fetch completes on ihit; loads and stores then wait in a data
// phase until dhit. HALT latches a sticky halted state that only RST leaves.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   ihit, dhit   instruction / data access complete this cycle
//   MemRead      current instruction is a load
//   MemWrite     current instruction is a store
//   halt         current instruction is HALT
//   imemREN      instruction read request
//   dmemREN      data read request (registered)
//   dmemWEN      data write request (registered)
//   pc_en        one-cycle strobe: PC advances, instruction retires
//   rf_wen_gate  register-file write gate, identical to pc_en
//   halted       sticky halt indication (registered)
//   retired_cnt  retired instruction count, wraps
//   stall_cnt    cycles spent in the data phase, saturates at all-ones
// ---------------------------------------------------------------------------
module request_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             rf_wen_gate,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DATA   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  logic             dmem_ren_r;
  logic             dmem_wen_r;
  logic             halted_r;
  logic [CNT_W-1:0] retired_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             pc_en_s;
  logic             imem_ren_s;
  logic             mem_op_s;

  assign mem_op_s = MemRead | MemWrite;

  // Combinational request/strobe decode; pc_en must fire in the hit cycle itself.
  always_comb begin
    pc_en_s    = 1'b0;
    imem_ren_s = 1'b0;
    if (RST) begin
      // The fetch request stays up through reset so the first fetch starts at once.
      imem_ren_s = 1'b1;
      pc_en_s    = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          imem_ren_s = 1'b1;
          pc_en_s    = ihit & ~halt & ~mem_op_s;
        end
        ST_DATA: begin
          imem_ren_s = 1'b0;
          pc_en_s    = dhit;
        end
        ST_HALTED: begin
          imem_ren_s = 1'b0;
          pc_en_s    = 1'b0;
        end
        default: begin
          imem_ren_s = 1'b0;
          pc_en_s    = 1'b0;
        end
      endcase
    end
  end

  // State, latched data requests, sticky halt and the two counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_FETCH;
      dmem_ren_r    <= 1'b0;
      dmem_wen_r    <= 1'b0;
      halted_r      <= 1'b0;
      retired_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (pc_en_s) begin
        retired_cnt_r <= retired_cnt_r + CNT_ONE;
      end
      case (state_r)
        ST_FETCH: begin
          if (ihit) begin
            if (halt) begin
              // HALT wins over any memory flags carried by the same word.
              state_r  <= ST_HALTED;
              halted_r <= 1'b1;
            end else if (mem_op_s) begin
              // Requests are latched here; later MemRead/MemWrite changes are ignored.
              state_r    <= ST_DATA;
              dmem_ren_r <= MemRead;
              dmem_wen_r <= MemWrite;
            end
          end
        end
        ST_DATA: begin
          // The dhit cycle itself is still a stall cycle.
          if (stall_cnt_r != CNT_MAX) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
          end
          if (dhit) begin
            state_r    <= ST_FETCH;
            dmem_ren_r <= 1'b0;
            dmem_wen_r <= 1'b0;
          end
        end
        ST_HALTED: begin
          dmem_ren_r <= 1'b0;
          dmem_wen_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_FETCH;
          dmem_ren_r <= 1'b0;
          dmem_wen_r <= 1'b0;
        end
      endcase
    end
  end

  assign imemREN     = imem_ren_s;
  assign dmemREN     = dmem_ren_r;
  assign dmemWEN     = dmem_wen_r;
  assign pc_en       = pc_en_s;
  assign rf_wen_gate = pc_en_s;
  assign halted      = halted_r;
  assign retired_cnt = retired_cnt_r;
  assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_request_unit.sv
// ---------------------------------------------------------------------------
// tb_request_unit
// Directed bench for request_unit with a narrow counter width so that wrap
// and saturation are reachable. A transaction-level model predicts every
// output each cycle; literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_request_unit;

  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         ihit = 1'b0, dhit = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, halt = 1'b0;
  logic         imemREN, dmemREN, dmemWEN, pc_en, rf_wen_gate, halted;
  logic [W-1:0] retired_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;

  request_unit #(.CNT_W(W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .MemRead(MemRead),
    .MemWrite(MemWrite), .halt(halt), .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .pc_en(pc_en), .rf_wen_gate(rf_wen_gate),
    .halted(halted), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  // Model: is an access outstanding, which kinds, halted, plain integer counts.
  bit m_valid = 1'b0;
  bit m_waiting = 1'b0;
  bit m_rd = 1'b0, m_wr = 1'b0, m_halted = 1'b0;
  int m_retired = 0;
  int m_stalls = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_pc();
    if (RST) return 1'b0;
    if (m_halted) return 1'b0;
    if (m_waiting) return dhit;
    return ihit && !halt && !MemRead && !MemWrite;
  endfunction

  // Model update: an instruction retires when it completes; stalls count waiting cycles.
  always @(posedge CLK) begin
    if (RST) begin
      m_valid = 1'b1; m_waiting = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
      m_halted = 1'b0; m_retired = 0; m_stalls = 0;
    end else begin
      if (exp_pc()) m_retired = m_retired + 1;
      if (m_waiting) begin
        if (m_stalls < CMAX) m_stalls = m_stalls + 1;
        if (dhit) begin m_waiting = 1'b0; m_rd = 1'b0; m_wr = 1'b0; end
      end else if (!m_halted && ihit) begin
        if (halt) m_halted = 1'b1;
        else if (MemRead || MemWrite) begin
          m_waiting = 1'b1; m_rd = MemRead; m_wr = MemWrite;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("imemREN", int'(imemREN), int'(RST || (!m_halted && !m_waiting)));
      check("pc_en", int'(pc_en), int'(exp_pc()));
      check("rf_wen_gate", int'(rf_wen_gate), int'(exp_pc()));
      check("dmemREN", int'(dmemREN), int'(m_rd));
      check("dmemWEN", int'(dmemWEN), int'(m_wr));
      check("halted", int'(halted), int'(m_halted));
      check("retired_cnt", int'(retired_cnt), m_retired % (CMAX + 1));
      check("stall_cnt", int'(stall_cnt), m_stalls);
    end
  end

  task automatic drive(input bit ih, input bit dh, input bit mr, input bit mw, input bit hl);
    ihit = ih; dhit = dh; MemRead = mr; MemWrite = mw; halt = hl;
  endtask

  task automatic step(input bit ih, input bit dh, input bit mr, input bit mw, input bit hl);
    drive(ih, dh, mr, mw, hl);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    // Reset cycle
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("lit_reset_imemREN", int'(imemREN), 1);
    check("lit_reset_pc_en", int'(pc_en), 0);
    @(posedge CLK); #2;
    RST = 1'b0;
    check("lit_reset_retired", int'(retired_cnt), 0);
    check("lit_reset_stall", int'(stall_cnt), 0);

    // 1: three plain instructions
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      check("lit_s1_pc_en", int'(pc_en), 1);
      @(posedge CLK); #2;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_s1_retired", int'(retired_cnt), 3);
    check("lit_s1_stall", int'(stall_cnt), 0);

    // 2: load, dhit in the 4th data cycle
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("lit_s2_dmemREN", int'(dmemREN), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("lit_s2_pc_dhit", int'(pc_en), 1);
    @(posedge CLK); #2;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_s2_dmemREN_drop", int'(dmemREN), 0);
    check("lit_s2_stall", int'(stall_cnt), 4);
    check("lit_s2_retired", int'(retired_cnt), 4);

    // 3: store completing in the first data cycle
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lit_s3_dmemWEN", int'(dmemWEN), 1);
    check("lit_s3_dmemREN", int'(dmemREN), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lit_s3_dmemWEN_drop", int'(dmemWEN), 0);
    check("lit_s3_stall", int'(stall_cnt), 5);
    check("lit_s3_retired", int'(retired_cnt), 5);

    // 4: halt together with MemWrite, then stray hits
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lit_s4_halted", int'(halted), 1);
    check("lit_s4_dmemWEN", int'(dmemWEN), 0);
    for (int i = 0; i < 4; i++) step(1'(i % 2 == 0), 1'(i % 2 == 1), 1'b1, 1'b0, 1'b0);
    check("lit_s4_retired_frozen", int'(retired_cnt), 5);
    check("lit_s4_imemREN", int'(imemREN), 0);

    // 5: reset in the 2nd data cycle of a load, then dhit in fetch
    RST = 1'b1; step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); RST = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1; step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_s5_dmemREN", int'(dmemREN), 0);
    check("lit_s5_stall", int'(stall_cnt), 0);
    check("lit_s5_retired", int'(retired_cnt), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("lit_s5_dhit_fetch", int'(pc_en), 0);
    @(posedge CLK); #2;

    // 6: retired wrap after 16 retirements, stall saturation over 20 data cycles
    for (int i = 0; i < CMAX; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_s6_retired_max", int'(retired_cnt), CMAX);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_s6_retired_wrap", int'(retired_cnt), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_s6_stall_sat", int'(stall_cnt), CMAX);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lit_s6_stall_hold", int'(stall_cnt), CMAX);
    check("lit_s6_retired_after", int'(retired_cnt), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
